// File: rtl/riscv_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state and access owner.
// Also holds the saturation limit of the optional statistics counters.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port; grant is combinational in IDLE, rvalid one cycle after mem_ready_i; stats ports under MEM_ARB_STATS_EN.
// Backpressure: one outstanding access held until mem_ready_i; no grants while an access is in flight.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       if_wait_cnt_o,
  output logic [15:0]       d_gnt_cnt_o
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t        state, state_nxt;
  arb_owner_t        gnt_owner;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_gnt;
  logic              if_done, d_done;

  always_comb begin
    if_gnt_o  = 1'b0;
    d_gnt_o   = 1'b0;
    gnt_owner = OWN_D;
    state_nxt = state;
    case (state)
      IDLE: begin
        // Grants are suppressed while reset is asserted so nothing is accepted into a reset.
        if (!rst && if_req_i && (!d_req_i || starve_cnt == STARVE_LIM)) begin
          if_gnt_o  = 1'b1;
          gnt_owner = OWN_IF;
          state_nxt = IF_ACC;
        end else if (!rst && d_req_i) begin
          d_gnt_o   = 1'b1;
          gnt_owner = OWN_D;
          state_nxt = D_ACC;
        end
      end
      IF_ACC, D_ACC: begin
        if (mem_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign any_gnt = if_gnt_o | d_gnt_o;
  assign if_done = (state == IF_ACC) && mem_ready_i;
  assign d_done  = (state == D_ACC) && mem_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
    end else begin
      state       <= state_nxt;
      if_rvalid_o <= if_done;
      d_rvalid_o  <= d_done;
      if (if_done) if_rdata_o <= mem_rdata_i;
      if (d_done)  d_rdata_o  <= mem_rdata_i;

      if (any_gnt) begin
        addr_q  <= (gnt_owner == OWN_IF) ? if_addr_i : d_addr_i;
        we_q    <= (gnt_owner == OWN_D) && d_we_i;
        wdata_q <= ((gnt_owner == OWN_D) && d_we_i) ? d_wdata_i : '0;
      end

      if (state == IDLE) begin
        if (if_gnt_o || !if_req_i)
          starve_cnt <= '0;
        else if (d_gnt_o && starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign mem_req_o   = (state != IDLE);
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state != IDLE) || any_gnt;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_wait_cnt_o <= '0;
      d_gnt_cnt_o   <= '0;
    end else begin
      if (if_req_i && !if_gnt_o && if_wait_cnt_o != STAT_MAX)
        if_wait_cnt_o <= if_wait_cnt_o + 16'd1;
      if (d_gnt_o && d_gnt_cnt_o != STAT_MAX)
        d_gnt_cnt_o <= d_gnt_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Build with MEM_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, if_req, d_req, d_we, mem_ready;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] if_wait_cnt, d_gnt_cnt;
`endif

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .busy_o(busy)
`ifdef MEM_ARB_STATS_EN
    , .if_wait_cnt_o(if_wait_cnt), .d_gnt_cnt_o(d_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Staged stimulus, applied shortly after each rising edge.
  logic        s_rst, s_if_req, s_d_req, s_d_we, s_ready;
  logic [15:0] s_if_addr, s_d_addr, s_d_wdata, s_rdata;

  // Transaction-level model: is an access in flight, who owns it, and what it carries.
  bit          m_busy, m_own_d, m_we, m_ifrv, m_drv;
  logic [15:0] m_addr, m_wdata, m_ifrd, m_drd;
  int          m_starve, m_ifw, m_dgc;

  int  n_vec, n_cmp, n_fail, cyc_no;
  bit  chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp);
    end
  endtask

  task automatic model_step();
    bit fetch_first, e_if_gnt, e_d_gnt, done;
    fetch_first = if_req && (!d_req || m_starve == STARVE_MAX);
    e_if_gnt = !rst && !m_busy && fetch_first;
    e_d_gnt  = !rst && !m_busy && d_req && !fetch_first;
    if (chk_en) begin
      n_vec++;
      chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
      chk("busy", 32'(busy), 32'(m_busy || e_if_gnt || e_d_gnt));
      chk("mem_req", 32'(mem_req), 32'(m_busy));
      if (m_busy) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(m_ifrv));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_drv));
      chk("if_rdata", 32'(if_rdata), 32'(m_ifrd));
      chk("d_rdata", 32'(d_rdata), 32'(m_drd));
`ifdef MEM_ARB_STATS_EN
      chk("if_wait_cnt", 32'(if_wait_cnt), 32'(m_ifw));
      chk("d_gnt_cnt", 32'(d_gnt_cnt), 32'(m_dgc));
`endif
    end
    if (rst) begin
      m_busy = 0; m_own_d = 0; m_we = 0; m_ifrv = 0; m_drv = 0;
      m_addr = '0; m_wdata = '0; m_ifrd = '0; m_drd = '0;
      m_starve = 0; m_ifw = 0; m_dgc = 0;
    end else begin
      done   = m_busy && mem_ready;
      m_ifrv = done && !m_own_d;
      m_drv  = done && m_own_d;
      if (m_ifrv) m_ifrd = mem_rdata;
      if (m_drv)  m_drd  = mem_rdata;
      if (!m_busy) begin
        if (e_if_gnt || !if_req) m_starve = 0;
        else if (e_d_gnt) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      end
      if (if_req && !e_if_gnt && m_ifw < 65535) m_ifw++;
      if (e_d_gnt && m_dgc < 65535) m_dgc++;
      if (done) m_busy = 0;
      if (e_if_gnt) begin
        m_busy = 1; m_own_d = 0; m_addr = if_addr; m_we = 0; m_wdata = '0;
      end else if (e_d_gnt) begin
        m_busy = 1; m_own_d = 1; m_addr = d_addr; m_we = d_we;
        m_wdata = d_we ? d_wdata : 16'h0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rst = s_rst; if_req = s_if_req; if_addr = s_if_addr;
    d_req = s_d_req; d_we = s_d_we; d_addr = s_d_addr; d_wdata = s_d_wdata;
    mem_ready = s_ready; mem_rdata = s_rdata;
    #2;
    model_step();
    cyc_no++;
  endtask

  task automatic quiet();
    s_rst = 0; s_if_req = 0; s_d_req = 0; s_d_we = 0; s_ready = 0;
    s_if_addr = '0; s_d_addr = '0; s_d_wdata = '0; s_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nrv;
    bit got;
    n_vec = 0; n_cmp = 0; n_fail = 0; cyc_no = 0; chk_en = 0;
    rst = 1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    quiet();
    s_rst = 1;
    cyc();
    chk_en = 1;
    cyc();
    s_rst = 0;
    cyc();
    chk("reset_mem_req", 32'(mem_req), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_if_rdata", 32'(if_rdata), 0);

    // Solo fetch: grant at 0, mem_req at 1, ready at 2, rvalid at 3.
    s_if_req = 1; s_if_addr = 16'h0010; cyc();
    chk("solo_if_gnt", 32'(if_gnt), 1);
    chk("solo_no_mem_req_c0", 32'(mem_req), 0);
    s_if_req = 0; cyc();
    chk("solo_mem_req_c1", 32'(mem_req), 1);
    chk("solo_mem_addr", 32'(mem_addr), 32'h0010);
    s_ready = 1; s_rdata = 16'hA5A5; cyc();
    s_ready = 0; s_rdata = 16'h0; cyc();
    chk("solo_if_rvalid_c3", 32'(if_rvalid), 1);
    chk("solo_if_rdata", 32'(if_rdata), 32'hA5A5);

    // Simultaneous requests: data write first, fetch in the next IDLE.
    s_if_req = 1; s_if_addr = 16'h0040;
    s_d_req = 1; s_d_we = 1; s_d_addr = 16'h0020; s_d_wdata = 16'h1234; cyc();
    chk("simul_d_gnt", 32'(d_gnt), 1);
    chk("simul_if_gnt_lo", 32'(if_gnt), 0);
    s_d_req = 0; s_ready = 1; cyc();
    chk("simul_mem_we", 32'(mem_we), 1);
    chk("simul_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("simul_mem_addr", 32'(mem_addr), 32'h0020);
    s_ready = 0; cyc();
    chk("simul_if_gnt_after", 32'(if_gnt), 1);
    chk("simul_d_rvalid", 32'(d_rvalid), 1);
    s_if_req = 0; s_ready = 1; cyc();
    quiet(); cyc(); cyc();

    // Starvation: both requesters held high, memory always ready.
    s_if_req = 1; s_d_req = 1; s_ready = 1; s_if_addr = 16'h0100; s_d_addr = 16'h0200;
    nd = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (if_gnt) begin got = 1; break; end
      if (d_gnt) nd++;
    end
    chk("starve_fetch_seen", 32'(got), 1);
    chk("starve_data_grants", 32'(nd), 4);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (if_gnt || d_gnt) begin got = d_gnt; break; end
    end
    chk("starve_cleared_data_next", 32'(got), 1);
    quiet(); s_ready = 1; cyc(); cyc(); s_ready = 0; cyc();

    // Wait states: five stalled cycles, then exactly one rvalid.
    s_if_req = 1; s_if_addr = 16'h0BEE; cyc();
    chk("wait_if_gnt", 32'(if_gnt), 1);
    s_if_req = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("wait_mem_req", 32'(mem_req), 1);
      chk("wait_mem_addr", 32'(mem_addr), 32'h0BEE);
      chk("wait_busy", 32'(busy), 1);
    end
    s_ready = 1; s_rdata = 16'h5A5A; cyc();
    s_ready = 0; nrv = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      nrv += int'(if_rvalid);
    end
    chk("wait_one_rvalid", 32'(nrv), 1);

    // Reset during a data access abandons it; the next fetch works.
    s_d_req = 1; s_d_we = 1; s_d_addr = 16'h0030; s_d_wdata = 16'hBEEF; cyc();
    chk("rst_d_gnt", 32'(d_gnt), 1);
    s_d_req = 0; s_rst = 1; cyc();
    s_rst = 0; cyc();
    chk("rst_mem_req_off", 32'(mem_req), 0);
    chk("rst_no_d_rvalid", 32'(d_rvalid), 0);
    s_ready = 1; cyc();
    s_ready = 0; cyc();
    chk("rst_ready_ignored", 32'(d_rvalid), 0);
    s_if_req = 1; s_if_addr = 16'h0050; cyc();
    chk("rst_fetch_gnt", 32'(if_gnt), 1);
    s_if_req = 0; s_ready = 1; s_rdata = 16'hC3C3; cyc();
    s_ready = 0; cyc();
    chk("rst_fetch_rvalid", 32'(if_rvalid), 1);
    chk("rst_fetch_rdata", 32'(if_rdata), 32'hC3C3);

`ifdef MEM_ARB_STATS_EN
    quiet(); s_rst = 1; cyc(); s_rst = 0;
    s_if_req = 1; s_d_req = 1; s_d_we = 0; s_d_addr = 16'h0060; cyc();
    s_d_req = 0; cyc();
    s_ready = 1; cyc();
    s_ready = 0; cyc();
    s_if_req = 0; cyc();
    chk("stats_if_wait", 32'(if_wait_cnt), 3);
    chk("stats_d_gnt", 32'(d_gnt_cnt), 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      s_rst     = ($urandom_range(0, 99) == 0);
      s_if_req  = $urandom_range(0, 1) == 1;
      s_d_req   = $urandom_range(0, 1) == 1;
      s_d_we    = $urandom_range(0, 1) == 1;
      s_ready   = $urandom_range(0, 9) < 4;
      s_if_addr = 16'($urandom);
      s_d_addr  = 16'($urandom);
      s_d_wdata = 16'($urandom);
      s_rdata   = 16'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
